control_fsm_mc: RTL and testbench

CONTROL_FSM_MC -- requirements
Module: control_fsm_mc

---
 rtl/control_fsm_mc.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_control_fsm_mc.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm_mc.sv
// -----------------------------------------------------------------------------
// control_fsm_mc
//
// Multi-cycle datapath controller. A state register steps through fetch,
// decode, execute, memory and write-back phases. Every control output is
// decoded combinationally from the current state and the instruction word.
// MEM_RD also uses dmem_ready for load_mdr. Illegal instructions and
// data-memory timeouts divert to an exception state. That state redirects the
// PC and reports a cause code, which is held in a register.
//
// Parameters
//   MEM_HANDSHAKE  1: memory states wait for dmem_ready; 0: memory states
//                  last exactly one cycle.
//   MEM_TIMEOUT    number of consecutive memory-wait cycles before a timeout
//                  exception; 0 disables the timeout.
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset (forces BOOT)
//   instruction    current IR contents
//   dmem_ready     data memory access complete
//   pc_write .. load_cause   single-bit datapath controls
//   pc_src         00 PC+4, 01 ALUOut, 10 exception vector
//   alu_src_b, alu_funct, mem_to_reg, branch_op, shift_control
//                  multi-bit datapath selects
//   cause          01 illegal instruction, 10 memory timeout (valid in EXC)
//   state          current state encoding
// -----------------------------------------------------------------------------
module control_fsm_mc #(
   parameter int MEM_HANDSHAKE = 1,
   parameter int MEM_TIMEOUT   = 15
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] instruction,
   input  logic        dmem_ready,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        alu_src_a,
   output logic        load_reg_a,
   output logic        load_reg_b,
   output logic        load_alu_out,
   output logic        write_reg,
   output logic        load_ir,
   output logic        dmem_req,
   output logic        dmem_write,
   output logic        load_mdr,
   output logic        load_epc,
   output logic        load_cause,
   output logic [1:0]  pc_src,
   output logic [1:0]  alu_src_b,
   output logic [2:0]  alu_funct,
   output logic [2:0]  mem_to_reg,
   output logic [1:0]  branch_op,
   output logic [1:0]  shift_control,
   output logic [1:0]  cause,
   output logic [4:0]  state
);

   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

   typedef enum logic [4:0] {
      S_FETCH   = 5'd0,
      S_DECODE  = 5'd1,
      S_ADDR    = 5'd2,
      S_EXEC_R  = 5'd3,
      S_MEM_RD  = 5'd5,
      S_MEM_WR  = 5'd6,
      S_LUI     = 5'd7,
      S_BRANCH  = 5'd8,
      S_BR_WAIT = 5'd9,
      S_WB_ALU  = 5'd10,
      S_WB_MEM  = 5'd11,
      S_SHIFT   = 5'd12,
      S_EXC     = 5'd13,
      S_BOOT    = 5'd15
   } state_t;

   localparam logic [6:0] OP_R        = 7'b0110011;
   localparam logic [6:0] OP_STORE    = 7'b0100011;
   localparam logic [6:0] OP_LOAD     = 7'b0000011;
   localparam logic [6:0] OP_IMM      = 7'b0010011;
   localparam logic [6:0] OP_LUI      = 7'b0110111;
   localparam logic [6:0] OP_BEQ      = 7'b1100011;
   localparam logic [6:0] OP_BRANCH_X = 7'b1100111;

   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   wait_cnt;
   logic [1:0]         cause_q, cause_d;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [5:0] shift_hi;
   logic       in_mem;
   logic       mem_wait;
   logic       timeout_hit;
   logic       r_legal;
   logic [2:0] r_funct;
   logic       illegal;

   assign opcode   = instruction[6:0];
   assign funct3   = instruction[14:12];
   assign funct7   = instruction[31:25];
   assign shift_hi = instruction[31:26];

   // Register and immediate fields feed the datapath directly, not this FSM.
   logic unused_fields;
   assign unused_fields = ^{instruction[24:15], instruction[11:7]};

   assign in_mem      = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
   assign mem_wait    = (MEM_HANDSHAKE != 0) && !dmem_ready;
   // Fires on the wait cycle that completes MEM_TIMEOUT consecutive waits.
   // If dmem_ready arrives in that same cycle, mem_wait is low and the normal
   // transition is taken.
   assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

   // R-type {funct7, funct3} to ALU operation; anything unlisted is illegal.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
      r_legal = 1'b1;
      r_funct = 3'b000;
      case ({funct7, funct3})
         10'b0000000_000: r_funct = 3'b001;
         10'b0100000_000: r_funct = 3'b010;
         10'b0000000_111: r_funct = 3'b011;
         default:         r_legal = 1'b0;
      endcase
   end

   // Next-state and cause selection.
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      illegal = 1'b0;
      case (state_q)
         S_BOOT:  state_d = S_FETCH;
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_R:              state_d = S_EXEC_R;
               OP_STORE, OP_LOAD: state_d = S_ADDR;
               OP_IMM: begin
                  case (funct3)
                     3'b000: state_d = S_ADDR;
                     3'b001: if (shift_hi == 6'b000000) state_d = S_SHIFT;
                             else illegal = 1'b1;
                     3'b101: if (shift_hi == 6'b000000 || shift_hi == 6'b010000) state_d = S_SHIFT;
                             else illegal = 1'b1;
                     default: illegal = 1'b1;
                  endcase
               end
               OP_LUI: state_d = S_LUI;
               OP_BEQ: if (funct3 == 3'b000) state_d = S_BRANCH;
                       else illegal = 1'b1;
               OP_BRANCH_X: begin
                  if (funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b101) state_d = S_BRANCH;
                  else illegal = 1'b1;
               end
               default: illegal = 1'b1;
            endcase
         end
         S_EXEC_R: begin
            if (r_legal) state_d = S_WB_ALU;
            else         illegal = 1'b1;
         end
         S_ADDR: begin
            case (opcode)
               OP_STORE: state_d = S_MEM_WR;
               OP_LOAD:  state_d = S_MEM_RD;
               OP_IMM:   state_d = S_WB_ALU;
               default:  illegal = 1'b1;
            endcase
         end
         S_MEM_RD, S_MEM_WR: begin
            if (mem_wait) begin
               if (timeout_hit) begin
                  state_d = S_EXC;
                  cause_d = CAUSE_TIMEOUT;
               end
            end else begin
               state_d = (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
            end
         end
         S_BRANCH: state_d = S_BR_WAIT;
         S_LUI, S_WB_ALU, S_WB_MEM, S_SHIFT, S_BR_WAIT, S_EXC: state_d = S_FETCH;
         default:  state_d = S_BOOT;
      endcase
      if (illegal) begin
         state_d = S_EXC;
         cause_d = CAUSE_ILLEGAL;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_BOOT;
         wait_cnt <= '0;
         cause_q  <= 2'b00;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         cause_q <= cause_d;
         // Counts only while a memory state holds. It reads zero on every
         // entry because it is cleared whenever the state moves.
         if (in_mem && (state_d == state_q)) begin
            if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
         end else begin
            wait_cnt <= '0;
         end
      end
   end

   // Output decode.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      alu_src_a     = 1'b0;
      load_reg_a    = 1'b0;
      load_reg_b    = 1'b0;
      load_alu_out  = 1'b0;
      write_reg     = 1'b0;
      load_ir       = 1'b0;
      dmem_req      = 1'b0;
      dmem_write    = 1'b0;
      load_mdr      = 1'b0;
      load_epc      = 1'b0;
      load_cause    = 1'b0;
      pc_src        = 2'b00;
      alu_src_b     = 2'b00;
      alu_funct     = 3'b000;
      mem_to_reg    = 3'b000;
      branch_op     = 2'b00;
      shift_control = 2'b00;
      cause         = 2'b00;
      case (state_q)
         S_FETCH: begin
            pc_write  = 1'b1;
            load_ir   = 1'b1;
            alu_src_b = 2'b01;
            alu_funct = 3'b001;
         end
         S_DECODE: begin
            load_reg_a   = 1'b1;
            load_reg_b   = 1'b1;
            load_alu_out = 1'b1;
            alu_src_b    = 2'b11;
            alu_funct    = 3'b001;
         end
         S_EXEC_R: begin
            alu_src_a    = 1'b1;
            alu_funct    = r_funct;
            load_alu_out = r_legal;
         end
         S_ADDR: begin
            alu_src_a    = 1'b1;
            alu_src_b    = 2'b10;
            alu_funct    = 3'b001;
            load_alu_out = 1'b1;
         end
         S_MEM_RD: begin
            dmem_req = 1'b1;
            load_mdr = (MEM_HANDSHAKE == 0) || dmem_ready;
         end
         S_MEM_WR: begin
            dmem_req   = 1'b1;
            dmem_write = 1'b1;
         end
         S_WB_ALU: begin
            write_reg  = 1'b1;
            mem_to_reg = 3'b000;
         end
         S_WB_MEM: begin
            write_reg  = 1'b1;
            mem_to_reg = 3'b001;
         end
         S_LUI: begin
            write_reg  = 1'b1;
            mem_to_reg = 3'b010;
         end
         S_SHIFT: begin
            write_reg  = 1'b1;
            mem_to_reg = 3'b100;
            if (funct3 == 3'b101) shift_control = instruction[30] ? 2'b10 : 2'b01;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_funct     = 3'b010;
            pc_write_cond = 1'b1;
            pc_src        = 2'b01;
            case (funct3)
               3'b001:  branch_op = 2'b01;
               3'b101:  branch_op = 2'b10;
               3'b100:  branch_op = 2'b11;
               default: branch_op = 2'b00;
            endcase
         end
         S_EXC: begin
            pc_write   = 1'b1;
            pc_src     = 2'b10;
            load_epc   = 1'b1;
            load_cause = 1'b1;
            cause      = cause_q;
         end
         default: ;
      endcase
   end

   assign state = state_q;

endmodule

// File: tb/tb_control_fsm_mc.sv
// -----------------------------------------------------------------------------
// tb_control_fsm_mc
//
// Self-checking bench for control_fsm_mc (MEM_HANDSHAKE=1, MEM_TIMEOUT=15).
// Each instruction is generated from a chosen instruction kind. A reference
// model turns that kind and a memory-ready delay into the expected state path
// and the expected control word for every cycle. The bench runs directed
// scenarios first, then randomized instructions and delays. It includes reset
// pulses during a branch wait and inside a memory wait.
// -----------------------------------------------------------------------------
module tb_control_fsm_mc;

   localparam int TIMEOUT = 15;

   localparam logic [4:0] S_FETCH   = 5'd0;
   localparam logic [4:0] S_DECODE  = 5'd1;
   localparam logic [4:0] S_ADDR    = 5'd2;
   localparam logic [4:0] S_EXEC_R  = 5'd3;
   localparam logic [4:0] S_MEM_RD  = 5'd5;
   localparam logic [4:0] S_MEM_WR  = 5'd6;
   localparam logic [4:0] S_LUI     = 5'd7;
   localparam logic [4:0] S_BRANCH  = 5'd8;
   localparam logic [4:0] S_BR_WAIT = 5'd9;
   localparam logic [4:0] S_WB_ALU  = 5'd10;
   localparam logic [4:0] S_WB_MEM  = 5'd11;
   localparam logic [4:0] S_SHIFT   = 5'd12;
   localparam logic [4:0] S_EXC     = 5'd13;
   localparam logic [4:0] S_BOOT    = 5'd15;

   typedef enum int {
      K_ADD, K_SUB, K_AND, K_R_BAD, K_LOAD, K_STORE, K_ADDI, K_SLLI, K_SRLI,
      K_SRAI, K_SHIFT_BAD, K_LUI, K_BEQ, K_BNE, K_BLT, K_BGE, K_OP_BAD
   } kind_e;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       alu_src_a;
      logic       load_reg_a;
      logic       load_reg_b;
      logic       load_alu_out;
      logic       write_reg;
      logic       load_ir;
      logic       dmem_req;
      logic       dmem_write;
      logic       load_mdr;
      logic       load_epc;
      logic       load_cause;
      logic [1:0] pc_src;
      logic [1:0] alu_src_b;
      logic [2:0] alu_funct;
      logic [2:0] mem_to_reg;
      logic [1:0] branch_op;
      logic [1:0] shift_control;
      logic [1:0] cause;
   } ctl_t;

   logic        clk;
   logic        reset_n;
   logic [31:0] instruction;
   logic        dmem_ready;
   logic        pc_write, pc_write_cond, alu_src_a, load_reg_a, load_reg_b;
   logic        load_alu_out, write_reg, load_ir, dmem_req, dmem_write;
   logic        load_mdr, load_epc, load_cause;
   logic [1:0]  pc_src, alu_src_b, branch_op, shift_control, cause;
   logic [2:0]  alu_funct, mem_to_reg;
   logic [4:0]  state;
   ctl_t        obs;

   control_fsm_mc #(.MEM_HANDSHAKE(1), .MEM_TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .instruction  (instruction),
      .dmem_ready   (dmem_ready),
      .pc_write     (pc_write),
      .pc_write_cond(pc_write_cond),
      .alu_src_a    (alu_src_a),
      .load_reg_a   (load_reg_a),
      .load_reg_b   (load_reg_b),
      .load_alu_out (load_alu_out),
      .write_reg    (write_reg),
      .load_ir      (load_ir),
      .dmem_req     (dmem_req),
      .dmem_write   (dmem_write),
      .load_mdr     (load_mdr),
      .load_epc     (load_epc),
      .load_cause   (load_cause),
      .pc_src       (pc_src),
      .alu_src_b    (alu_src_b),
      .alu_funct    (alu_funct),
      .mem_to_reg   (mem_to_reg),
      .branch_op    (branch_op),
      .shift_control(shift_control),
      .cause        (cause),
      .state        (state)
   );

   assign obs = {pc_write, pc_write_cond, alu_src_a, load_reg_a, load_reg_b,
                 load_alu_out, write_reg, load_ir, dmem_req, dmem_write,
                 load_mdr, load_epc, load_cause, pc_src, alu_src_b, alu_funct,
                 mem_to_reg, branch_op, shift_control, cause};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [4:0] exp_path[$];
   logic [1:0] exp_cause;

   // Expected state sequence for one instruction, starting at FETCH.
   // delay = number of dmem_ready-low cycles before it rises.
   function automatic void plan(input kind_e k, input int delay);
      int  n;
      bit  tmo;
      tmo = (delay >= TIMEOUT);
      n   = tmo ? TIMEOUT : delay + 1;
      exp_path = '{S_FETCH, S_DECODE};
      exp_cause = tmo ? 2'b10 : 2'b01;
      case (k)
         K_ADD, K_SUB, K_AND: begin exp_path.push_back(S_EXEC_R); exp_path.push_back(S_WB_ALU); end
         K_R_BAD:             begin exp_path.push_back(S_EXEC_R); exp_path.push_back(S_EXC); end
         K_LOAD: begin
            exp_path.push_back(S_ADDR);
            for (int i = 0; i < n; i++) exp_path.push_back(S_MEM_RD);
            exp_path.push_back(tmo ? S_EXC : S_WB_MEM);
         end
         K_STORE: begin
            exp_path.push_back(S_ADDR);
            for (int i = 0; i < n; i++) exp_path.push_back(S_MEM_WR);
            if (tmo) exp_path.push_back(S_EXC);
         end
         K_ADDI:                  begin exp_path.push_back(S_ADDR); exp_path.push_back(S_WB_ALU); end
         K_SLLI, K_SRLI, K_SRAI:  exp_path.push_back(S_SHIFT);
         K_LUI:                   exp_path.push_back(S_LUI);
         K_BEQ, K_BNE, K_BLT, K_BGE: begin exp_path.push_back(S_BRANCH); exp_path.push_back(S_BR_WAIT); end
         default:                 exp_path.push_back(S_EXC);
      endcase
      if (k == K_R_BAD || k == K_SHIFT_BAD || k == K_OP_BAD) exp_cause = 2'b01;
   endfunction

   function automatic ctl_t exp_ctl(input logic [4:0] st, input kind_e k, input logic rdy, input logic [1:0] cz);
      ctl_t c;
      c = '0;
      case (st)
         S_FETCH:  begin c.pc_write = 1; c.load_ir = 1; c.alu_src_b = 2'b01; c.alu_funct = 3'b001; end
         S_DECODE: begin c.load_reg_a = 1; c.load_reg_b = 1; c.load_alu_out = 1; c.alu_src_b = 2'b11; c.alu_funct = 3'b001; end
         S_EXEC_R: begin
            c.alu_src_a = 1;
            c.load_alu_out = (k != K_R_BAD);
            c.alu_funct = (k == K_ADD) ? 3'b001 : (k == K_SUB) ? 3'b010 : (k == K_AND) ? 3'b011 : 3'b000;
         end
         S_ADDR:   begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_funct = 3'b001; c.load_alu_out = 1; end
         S_MEM_RD: begin c.dmem_req = 1; c.load_mdr = rdy; end
         S_MEM_WR: begin c.dmem_req = 1; c.dmem_write = 1; end
         S_WB_ALU: begin c.write_reg = 1; c.mem_to_reg = 3'b000; end
         S_WB_MEM: begin c.write_reg = 1; c.mem_to_reg = 3'b001; end
         S_LUI:    begin c.write_reg = 1; c.mem_to_reg = 3'b010; end
         S_SHIFT: begin
            c.write_reg = 1; c.mem_to_reg = 3'b100;
            c.shift_control = (k == K_SRAI) ? 2'b10 : (k == K_SRLI) ? 2'b01 : 2'b00;
         end
         S_BRANCH: begin
            c.alu_src_a = 1; c.alu_funct = 3'b010; c.pc_write_cond = 1; c.pc_src = 2'b01;
            c.branch_op = (k == K_BNE) ? 2'b01 : (k == K_BGE) ? 2'b10 : (k == K_BLT) ? 2'b11 : 2'b00;
         end
         S_EXC:    begin c.pc_write = 1; c.pc_src = 2'b10; c.load_epc = 1; c.load_cause = 1; c.cause = cz; end
         default: ;
      endcase
      return c;
   endfunction

   // Instruction generator: fixed fields from the kind, random don't-cares.
   function automatic logic [31:0] gen(input kind_e k);
      logic [31:0] r;
      logic [6:0]  f7, op;
      logic [2:0]  f3;
      logic [5:0]  hi;
      r = $urandom;
      case (k)
         K_ADD:   return {7'b0000000, r[24:15], 3'b000, r[11:7], 7'b0110011};
         K_SUB:   return {7'b0100000, r[24:15], 3'b000, r[11:7], 7'b0110011};
         K_AND:   return {7'b0000000, r[24:15], 3'b111, r[11:7], 7'b0110011};
         K_R_BAD: begin
            do begin
               f7 = r[0] ? 7'($urandom) : (r[1] ? 7'b0100000 : 7'b0000000);
               f3 = 3'($urandom);
               r[0] = ~r[0];
            end while ({f7, f3} inside {10'b0000000_000, 10'b0100000_000, 10'b0000000_111});
            return {f7, r[24:15], f3, r[11:7], 7'b0110011};
         end
         K_LOAD:  return {r[31:15], 3'($urandom), r[11:7], 7'b0000011};
         K_STORE: return {r[31:15], 3'($urandom), r[11:7], 7'b0100011};
         K_ADDI:  return {r[31:15], 3'b000, r[11:7], 7'b0010011};
         K_SLLI:  return {6'b000000, r[25:15], 3'b001, r[11:7], 7'b0010011};
         K_SRLI:  return {6'b000000, r[25:15], 3'b101, r[11:7], 7'b0010011};
         K_SRAI:  return {6'b010000, r[25:15], 3'b101, r[11:7], 7'b0010011};
         K_SHIFT_BAD: begin
            f3 = r[0] ? 3'b001 : 3'b101;
            do hi = 6'($urandom);
            while (hi == 6'b000000 || (f3 == 3'b101 && hi == 6'b010000));
            return {hi, r[25:15], f3, r[11:7], 7'b0010011};
         end
         K_LUI:   return {r[31:7], 7'b0110111};
         K_BEQ:   return {r[31:15], 3'b000, r[11:7], 7'b1100011};
         K_BNE:   return {r[31:15], 3'b001, r[11:7], 7'b1100111};
         K_BLT:   return {r[31:15], 3'b100, r[11:7], 7'b1100111};
         K_BGE:   return {r[31:15], 3'b101, r[11:7], 7'b1100111};
         default: begin
            case ($urandom_range(0, 3))
               0: begin
                  do op = 7'($urandom);
                  while (op inside {7'b0110011, 7'b0100011, 7'b0000011, 7'b0010011,
                                    7'b0110111, 7'b1100011, 7'b1100111});
                  return {r[31:7], op};
               end
               1: begin
                  do f3 = 3'($urandom); while (f3 inside {3'b000, 3'b001, 3'b101});
                  return {r[31:15], f3, r[11:7], 7'b0010011};
               end
               2: begin
                  do f3 = 3'($urandom); while (f3 == 3'b000);
                  return {r[31:15], f3, r[11:7], 7'b1100011};
               end
               default: begin
                  do f3 = 3'($urandom); while (f3 inside {3'b001, 3'b100, 3'b101});
                  return {r[31:15], f3, r[11:7], 7'b1100111};
               end
            endcase
         end
      endcase
   endfunction

   // ---------------- drivers ----------------
   // Runs one instruction from FETCH. Inputs change on the falling edge and
   // outputs are sampled 1 ns later. stop_at > 0 ends the run after that many
   // cycles, leaving the DUT mid-instruction.
   task automatic run_instr(input logic [31:0] ins, input kind_e k, input int delay, input int stop_at);
      int mem_idx;
      int last;
      mem_idx = 0;
      plan(k, delay);
      last = (stop_at > 0 && stop_at < exp_path.size()) ? stop_at : exp_path.size();
      for (int i = 0; i < last; i++) begin
         @(negedge clk);
         instruction = ins;
         if (exp_path[i] == S_MEM_RD || exp_path[i] == S_MEM_WR) begin
            dmem_ready = (mem_idx == delay);
            mem_idx++;
         end else begin
            dmem_ready = 1'($urandom);
         end
         #1;
         check($sformatf("%s state[%0d]", k.name(), i), 32'(state), 32'(exp_path[i]));
         check($sformatf("%s ctl[%0d] st%0d", k.name(), i, exp_path[i]), 32'(obs),
               32'(exp_ctl(exp_path[i], k, dmem_ready, exp_cause)));
      end
   endtask

   // Asserts reset mid-cycle, holds it across a rising edge, and releases it
   // on a falling edge. The next rising edge should give FETCH.
   task automatic pulse_reset(input string tag);
      #2 reset_n = 1'b0;
      #1;
      check({tag, " async state"}, 32'(state), 32'(S_BOOT));
      check({tag, " async ctl"}, 32'(obs), 32'd0);
      @(posedge clk); #1;
      check({tag, " held state"}, 32'(state), 32'(S_BOOT));
      check({tag, " held ctl"}, 32'(obs), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check({tag, " release state"}, 32'(state), 32'(S_BOOT));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      kind_e k;
      int    r, delay;

      reset_n     = 1'b1;
      instruction = '0;
      dmem_ready  = 1'b0;
      #3 reset_n  = 1'b0;
      #1;
      check("reset state", 32'(state), 32'(S_BOOT));
      check("reset ctl", 32'(obs), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("boot after release", 32'(state), 32'(S_BOOT));

      // Directed scenarios.
      run_instr(32'h002081B3, K_ADD, 0, 0);
      run_instr(32'h0000B183, K_LOAD, 3, 0);
      run_instr(32'h0030B023, K_STORE, 100, 0);
      run_instr(32'hFFFFFFFF, K_OP_BAD, 0, 0);
      run_instr({6'b010000, 6'd3, 5'd1, 3'b101, 5'd3, 7'b0010011}, K_SRAI, 0, 0);
      run_instr(gen(K_LOAD), K_LOAD, 14, 0);
      run_instr(gen(K_STORE), K_STORE, 14, 0);
      run_instr(gen(K_LOAD), K_LOAD, 15, 0);
      run_instr(gen(K_R_BAD), K_R_BAD, 0, 0);
      run_instr({7'b0, 5'd2, 5'd1, 3'b100, 5'd0, 7'b1100111}, K_BLT, 0, 0);
      pulse_reset("reset in BR_WAIT");
      run_instr(gen(K_LOAD), K_LOAD, 100, 6);
      pulse_reset("reset in MEM_RD wait");
      run_instr(gen(K_STORE), K_STORE, 100, 8);
      pulse_reset("reset in MEM_WR wait");

      // Randomized instructions and memory delays.
      repeat (80) begin
         k = kind_e'($urandom_range(0, 16));
         r = $urandom_range(0, 9);
         delay = (r < 7) ? $urandom_range(0, 4) : (r == 7) ? 14 : (r == 8) ? 15 : 40;
         run_instr(gen(k), k, delay, 0);
      end
      @(negedge clk); #1;
      check("final fetch", 32'(state), 32'(S_FETCH));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
